wb_select_stage: RTL and testbench
==================================

# wb_select_stage

Parametrised MEM/WB writeback stage for the pipelined MIPS datapath: registers the memory-stage results, selects the register-file write data from N source channels, aligns and extends sub-word loads, and presents write-back and forwarding outputs one cycle later. It sits between the data memory / CP0 read ports and the register-file write port and replaces the unregistered writeback multiplexer. It adds stall/flush control, load extraction, $zero write suppression and error flags.

## Interface
- DW, 32: datapath width; must be ≥ 32.
- NSRC, 5: number of write-data source channels; channel 0 = ALU result, 1 = DM read data, 2 = PC+4, 3 = constant/compare, 4 = CP0 read; extra channels are free for HI/LO etc.
- SELW, 3: select width; must satisfy 2^SELW ≥ NSRC.
- LD_CH, 1: channel index that receives load extraction.
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- stall  in  1  hold the pipeline register contents.
- flush  in  1  replace the captured instruction with a bubble.
- in_valid  in  1  memory-stage instruction is valid.
- wdsel  in  SELW  write-data source select.
- src_bus  in  NSRC*DW  packed sources; channel k = src_bus[k*DW +: DW].
- ld_mode  in  3  000 word, 001 byte signed, 010 byte unsigned, 011 half signed, 100 half unsigned; other codes are treated as word.
- addr_lo  in  2  low bits of the load address.
- rf_we_in  in  1  instruction writes the register file.
- rd_in  in  5  destination register.
- wb_data  out  DW  register-file write data.
- wb_we  out  1  register-file write enable.
- wb_rd  out  5  register-file write address.
- wb_valid  out  1  stage holds a valid instruction.
- sel_err  out  1  sticky: an out-of-range wdsel was captured.
- misalign  out  1  pulse: the captured load was misaligned.

## Operation
- Select: if wdsel < NSRC, the selected value is channel wdsel; otherwise the selected value is 0 and sel_err is set.
- sel_err stays set until rst.
- Load extraction applies only when wdsel == LD_CH, using the low 32 bits of the channel.
  - Byte lanes are little-endian: byte k = bits [8k+7:8k], with k = addr_lo.
  - Halfword lanes: addr_lo[1]=0 selects bits [15:0]; addr_lo[1]=1 selects bits [31:16].
  - Signed modes sign-extend to DW; unsigned modes zero-extend to DW.
  - Word mode passes the channel through unchanged.
- Misalignment: a halfword mode with addr_lo[0]=1, or word mode with addr_lo ≠ 0, when wdsel == LD_CH.
  - Data is still extracted as above, with the offending low address bits ignored.
  - The captured write enable is forced to 0.
  - misalign is 1 for that instruction's cycle in the stage.
- Write enable: wb_we = wb_valid & captured rf_we_in & (wb_rd ≠ 0) & ~misalign. A write to $zero is never issued.
- Register update on each edge, in priority order:
  - rst: clear everything.
  - flush: capture a bubble (valid, we, rd, data, misalign all 0).
  - stall: hold all state.
  - otherwise: capture the selected/extracted data, rd_in, rf_we_in, in_valid and the misalign result.
- When in_valid = 0, the captured valid is 0. Write enable is therefore 0, but data is still captured.

## Timing
- Latency: 1 cycle from the inputs to wb_* outputs. All outputs are registered; there are no combinational paths from input to output.
- rst: all outputs are 0 on the cycle after the edge on which rst is sampled high, including sel_err. Asserting rst mid-stall also clears.
- flush and stall together: flush wins and a bubble is inserted.
- stall held for N cycles: outputs are frozen for N cycles, and a stall does not re-pulse misalign. sel_err is only set on a capture edge, never during stall.
- wb_* outputs also serve as the WB-to-EX forwarding source in the same cycle.

## Test plan
- Reset: drive rst=1 for 2 cycles with random inputs -> all outputs 0; after release, wdsel=0, ALU=0x1234_5678, rd=8, we=1 -> next cycle wb_data=0x1234_5678, wb_we=1, wb_rd=8.
- Loads: DM=0x80FF_7F01 with each mode and each aligned addr_lo; e.g. byte signed at addr_lo=3 -> 0xFFFF_FF80, half unsigned at addr_lo=2 -> 0x0000_80FF, byte unsigned at addr_lo=1 -> 0x0000_007F.
- Misalign: half signed, addr_lo=1, we=1 -> wb_we=0 and misalign=1 for one cycle; word load at addr_lo=2 -> same response.
- Select range: wdsel=2 with PC+4=0x0040_0008 -> wb_data=0x0040_0008; wdsel=4 with CP0=0xDEAD_BEEF -> 0xDEAD_BEEF; wdsel=7 with NSRC=5 -> wb_data=0 and sel_err=1, which stays set after 10 further valid cycles.
- Stall/flush: capture a value, then stall=1 for 3 cycles with changing inputs -> outputs frozen; then stall=flush=1 -> wb_valid=0, wb_we=0, wb_data=0.
- $zero: rd=0, we=1, data=5 -> wb_we=0, wb_data=5.

Source files
------------

// File: rtl/wb_select_stage.sv
// MEM/WB writeback stage: registers memory-stage results, selects write data,
// aligns/extends sub-word loads and drives the register-file write port.
module wb_select_stage #(
  parameter int DW    = 32,
  parameter int NSRC  = 5,
  parameter int SELW  = 3,
  parameter int LD_CH = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 stall,
  input  logic                 flush,
  input  logic                 in_valid,
  input  logic [SELW-1:0]      wdsel,
  input  logic [NSRC*DW-1:0]   src_bus,
  input  logic [2:0]           ld_mode,
  input  logic [1:0]           addr_lo,
  input  logic                 rf_we_in,
  input  logic [4:0]           rd_in,
  output logic [DW-1:0]        wb_data,
  output logic                 wb_we,
  output logic [4:0]           wb_rd,
  output logic                 wb_valid,
  output logic                 sel_err,
  output logic                 misalign
);

  localparam logic [2:0] LM_BS = 3'b001;
  localparam logic [2:0] LM_BU = 3'b010;
  localparam logic [2:0] LM_HS = 3'b011;
  localparam logic [2:0] LM_HU = 3'b100;

  logic [DW-1:0] chan;
  logic          in_rng;
  logic          is_ld;
  logic          is_byte;
  logic          is_half;
  logic          is_word;
  logic [31:0]   w;
  logic [7:0]    bsel;
  logic [15:0]   hsel;
  logic [DW-1:0] seldata;
  logic          mis;

  logic [DW-1:0] data_q;
  logic [4:0]    rd_q;
  logic          we_q;
  logic          valid_q;
  logic          mis_q;
  logic          err_q;

  always_comb begin
    chan   = '0;
    in_rng = 1'b0;
    for (int k = 0; k < NSRC; k++) begin
      if (wdsel == SELW'(k)) begin
        chan   = src_bus[k*DW +: DW];
        in_rng = 1'b1;
      end
    end
  end

  assign is_ld   = (wdsel == SELW'(LD_CH));
  assign is_byte = (ld_mode == LM_BS) || (ld_mode == LM_BU);
  assign is_half = (ld_mode == LM_HS) || (ld_mode == LM_HU);
  assign is_word = ~is_byte & ~is_half;
  assign w       = chan[31:0];
  assign hsel    = addr_lo[1] ? w[31:16] : w[15:0];

  always_comb begin
    unique case (addr_lo)
      2'd0:    bsel = w[7:0];
      2'd1:    bsel = w[15:8];
      2'd2:    bsel = w[23:16];
      default: bsel = w[31:24];
    endcase
  end

  always_comb begin
    seldata = chan;
    if (is_ld) begin
      case (ld_mode)
        LM_BS:   seldata = {{(DW-8){bsel[7]}}, bsel};
        LM_BU:   seldata = {{(DW-8){1'b0}}, bsel};
        LM_HS:   seldata = {{(DW-16){hsel[15]}}, hsel};
        LM_HU:   seldata = {{(DW-16){1'b0}}, hsel};
        default: seldata = chan;
      endcase
    end
  end

  // Misaligned loads still extract data but never write the register file.
  assign mis = is_ld & ((is_half & addr_lo[0]) | (is_word & (|addr_lo)));

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q  <= '0;
      rd_q    <= '0;
      we_q    <= 1'b0;
      valid_q <= 1'b0;
      mis_q   <= 1'b0;
      err_q   <= 1'b0;
    end else if (flush) begin
      data_q  <= '0;
      rd_q    <= '0;
      we_q    <= 1'b0;
      valid_q <= 1'b0;
      mis_q   <= 1'b0;
    end else if (!stall) begin
      data_q  <= seldata;
      rd_q    <= rd_in;
      we_q    <= rf_we_in & ~mis;
      valid_q <= in_valid;
      mis_q   <= mis;
      if (!in_rng) err_q <= 1'b1;
    end
  end

  assign wb_data  = data_q;
  assign wb_rd    = rd_q;
  assign wb_valid = valid_q;
  assign misalign = mis_q;
  assign sel_err  = err_q;
  assign wb_we    = valid_q & we_q & (|rd_q) & ~mis_q;

endmodule

// File: tb/tb_wb_select_stage.sv
// Directed vector bench for wb_select_stage: load lanes, select range,
// misalignment, stall/flush priority, $zero suppression and reset.
module tb_wb_select_stage;

  localparam int DW   = 32;
  localparam int NSRC = 5;
  localparam int SELW = 3;

  localparam logic [31:0] PC4 = 32'h0040_0008;
  localparam logic [31:0] CST = 32'h0000_0001;
  localparam logic [31:0] CP0 = 32'hDEAD_BEEF;
  localparam logic [31:0] DMV = 32'h80FF_7F01;

  logic              clk = 1'b0;
  logic              rst;
  logic              stall;
  logic              flush;
  logic              in_valid;
  logic [SELW-1:0]   wdsel;
  logic [NSRC*DW-1:0] src_bus;
  logic [2:0]        ld_mode;
  logic [1:0]        addr_lo;
  logic              rf_we_in;
  logic [4:0]        rd_in;
  logic [DW-1:0]     wb_data;
  logic              wb_we;
  logic [4:0]        wb_rd;
  logic              wb_valid;
  logic              sel_err;
  logic              misalign;

  int checks = 0;
  int failures = 0;

  wb_select_stage #(
    .DW(DW), .NSRC(NSRC), .SELW(SELW), .LD_CH(1)
  ) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .in_valid(in_valid), .wdsel(wdsel), .src_bus(src_bus),
    .ld_mode(ld_mode), .addr_lo(addr_lo), .rf_we_in(rf_we_in),
    .rd_in(rd_in), .wb_data(wb_data), .wb_we(wb_we), .wb_rd(wb_rd),
    .wb_valid(wb_valid), .sel_err(sel_err), .misalign(misalign)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  sel;
    logic [2:0]  mode;
    logic [1:0]  a;
    logic        v;
    logic        we;
    logic [4:0]  rd;
    logic [31:0] alu;
    logic [31:0] xd;
    logic        xwe;
    logic        xmis;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic [2:0] sel, input logic [2:0] mode,
                     input logic [1:0] a, input logic v, input logic we,
                     input logic [4:0] rd, input logic [31:0] alu,
                     input logic [31:0] xd, input logic xwe,
                     input logic xmis);
    vec_t t;
    t.sel = sel; t.mode = mode; t.a = a; t.v = v; t.we = we;
    t.rd = rd; t.alu = alu; t.xd = xd; t.xwe = xwe; t.xmis = xmis;
    vq.push_back(t);
  endtask

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic [2:0] sel, input logic [2:0] mode,
                       input logic [1:0] a, input logic v, input logic we,
                       input logic [4:0] rd, input logic [31:0] alu);
    wdsel    = sel;
    ld_mode  = mode;
    addr_lo  = a;
    in_valid = v;
    rf_we_in = we;
    rd_in    = rd;
    src_bus  = {CP0, CST, PC4, DMV, alu};
  endtask

  task automatic drive_rand();
    wdsel    = 3'($urandom_range(0, 4));
    ld_mode  = 3'($urandom);
    addr_lo  = 2'($urandom);
    in_valid = 1'($urandom);
    rf_we_in = 1'($urandom);
    rd_in    = 5'($urandom);
    src_bus  = {$urandom, $urandom, $urandom, $urandom, $urandom};
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, ".data"}, wb_data, 32'h0);
    chk({nm, ".we"}, 32'(wb_we), 32'h0);
    chk({nm, ".rd"}, 32'(wb_rd), 32'h0);
    chk({nm, ".valid"}, 32'(wb_valid), 32'h0);
    chk({nm, ".err"}, 32'(sel_err), 32'h0);
    chk({nm, ".mis"}, 32'(misalign), 32'h0);
  endtask

  initial begin
    logic [31:0] hd;
    logic [4:0]  hrd;

    add(0, 0, 0, 1, 1,  8, 32'h1234_5678, 32'h1234_5678, 1, 0);
    add(1, 0, 0, 1, 1,  9, 32'h0,         32'h80FF_7F01, 1, 0);
    add(1, 1, 0, 1, 1, 10, 32'h0,         32'h0000_0001, 1, 0);
    add(1, 1, 1, 1, 1, 10, 32'h0,         32'h0000_007F, 1, 0);
    add(1, 1, 2, 1, 1, 10, 32'h0,         32'hFFFF_FFFF, 1, 0);
    add(1, 1, 3, 1, 1, 10, 32'h0,         32'hFFFF_FF80, 1, 0);
    add(1, 2, 0, 1, 1, 11, 32'h0,         32'h0000_0001, 1, 0);
    add(1, 2, 1, 1, 1, 11, 32'h0,         32'h0000_007F, 1, 0);
    add(1, 2, 2, 1, 1, 11, 32'h0,         32'h0000_00FF, 1, 0);
    add(1, 2, 3, 1, 1, 11, 32'h0,         32'h0000_0080, 1, 0);
    add(1, 3, 0, 1, 1, 12, 32'h0,         32'h0000_7F01, 1, 0);
    add(1, 3, 2, 1, 1, 12, 32'h0,         32'hFFFF_80FF, 1, 0);
    add(1, 4, 0, 1, 1, 13, 32'h0,         32'h0000_7F01, 1, 0);
    add(1, 4, 2, 1, 1, 13, 32'h0,         32'h0000_80FF, 1, 0);
    add(1, 3, 1, 1, 1, 14, 32'h0,         32'h0000_7F01, 0, 1);
    add(1, 0, 2, 1, 1, 14, 32'h0,         32'h80FF_7F01, 0, 1);
    add(1, 4, 3, 1, 1, 14, 32'h0,         32'h0000_80FF, 0, 1);
    add(0, 3, 1, 1, 1, 15, 32'hCAFE_F00D, 32'hCAFE_F00D, 1, 0);
    add(2, 0, 0, 1, 1, 31, 32'h0,         32'h0040_0008, 1, 0);
    add(4, 0, 0, 1, 1, 16, 32'h0,         32'hDEAD_BEEF, 1, 0);
    add(3, 0, 0, 1, 1, 17, 32'h0,         32'h0000_0001, 1, 0);
    add(0, 0, 0, 1, 1,  0, 32'h0000_0005, 32'h0000_0005, 0, 0);
    add(0, 0, 0, 0, 1, 18, 32'hAAAA_5555, 32'hAAAA_5555, 0, 0);
    add(1, 7, 0, 1, 1, 19, 32'h0,         32'h80FF_7F01, 1, 0);
    add(1, 5, 1, 1, 1, 19, 32'h0,         32'h80FF_7F01, 0, 1);
    add(1, 2, 1, 1, 0, 20, 32'h0,         32'h0000_007F, 0, 0);

    // Reset for two cycles with random inputs.
    rst = 1'b1; stall = 1'b0; flush = 1'b0;
    drive_rand();
    for (int i = 0; i < 2; i++) begin
      tick();
      chk_zero($sformatf("rst%0d", i));
      drive_rand();
      stall = 1'($urandom);
      flush = 1'($urandom);
    end
    rst = 1'b0; stall = 1'b0; flush = 1'b0;

    for (int i = 0; i < vq.size(); i++) begin
      drive(vq[i].sel, vq[i].mode, vq[i].a, vq[i].v, vq[i].we,
            vq[i].rd, vq[i].alu);
      tick();
      chk($sformatf("v%0d.data", i), wb_data, vq[i].xd);
      chk($sformatf("v%0d.we", i), 32'(wb_we), 32'(vq[i].xwe));
      chk($sformatf("v%0d.rd", i), 32'(wb_rd), 32'(vq[i].rd));
      chk($sformatf("v%0d.valid", i), 32'(wb_valid), 32'(vq[i].v));
      chk($sformatf("v%0d.mis", i), 32'(misalign), 32'(vq[i].xmis));
      chk($sformatf("v%0d.err", i), 32'(sel_err), 32'h0);
    end

    // Stall freezes outputs for three cycles; out-of-range select ignored.
    drive(0, 0, 0, 1, 1, 3, 32'h1111_2222);
    tick();
    hd = wb_data; hrd = wb_rd;
    chk("stall.cap", wb_data, 32'h1111_2222);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(3'd7, 3'($urandom), 2'($urandom), 1'b1, 1'b1,
            5'($urandom_range(1, 31)), $urandom);
      tick();
      chk($sformatf("stall%0d.data", i), wb_data, hd);
      chk($sformatf("stall%0d.rd", i), 32'(wb_rd), 32'(hrd));
      chk($sformatf("stall%0d.we", i), 32'(wb_we), 32'h1);
      chk($sformatf("stall%0d.valid", i), 32'(wb_valid), 32'h1);
      chk($sformatf("stall%0d.err", i), 32'(sel_err), 32'h0);
    end
    flush = 1'b1;
    drive(0, 0, 0, 1, 1, 6, 32'h7777_7777);
    tick();
    chk("flush.valid", 32'(wb_valid), 32'h0);
    chk("flush.we", 32'(wb_we), 32'h0);
    chk("flush.data", wb_data, 32'h0);
    chk("flush.rd", 32'(wb_rd), 32'h0);
    stall = 1'b0; flush = 1'b0;

    // Misaligned load frozen under stall, cleared by next aligned capture.
    drive(1, 3, 1, 1, 1, 4, 32'h0);
    tick();
    chk("mstall.mis0", 32'(misalign), 32'h1);
    stall = 1'b1;
    drive(1, 0, 0, 1, 1, 4, 32'h0);
    tick();
    chk("mstall.mis1", 32'(misalign), 32'h1);
    chk("mstall.we1", 32'(wb_we), 32'h0);
    stall = 1'b0;
    tick();
    chk("mstall.mis2", 32'(misalign), 32'h0);
    chk("mstall.we2", 32'(wb_we), 32'h1);

    // Out-of-range select: zero data, sticky error.
    drive(3'd7, 0, 0, 1, 1, 21, 32'h5555_5555);
    tick();
    chk("sel7.data", wb_data, 32'h0);
    chk("sel7.err", 32'(sel_err), 32'h1);
    for (int i = 0; i < 10; i++) begin
      drive(0, 0, 0, 1, 1, 22, 32'(i));
      tick();
    end
    chk("sticky.err", 32'(sel_err), 32'h1);
    chk("sticky.data", wb_data, 32'd9);

    // Reset asserted during a stall clears everything, including sel_err.
    stall = 1'b1; rst = 1'b1;
    tick();
    chk_zero("rststall");
    rst = 1'b0; stall = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
